// File: rtl/onchip_memory_read_master.sv
// Avalon-MM pipelined read master: streams a block of 32-bit words from memory
// onto a ready/valid stream through a credit-limited read-data FIFO.
module onchip_memory_read_master #(
   parameter int ADDR_WIDTH = 14,
   parameter int LEN_WIDTH  = 13,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic [3:0]            avm_byteenable,
   input  logic                  avm_waitrequest,
   input  logic [31:0]           avm_readdata,
   input  logic                  avm_readdatavalid,
   output logic [31:0]           st_data,
   output logic                  st_valid,
   input  logic                  st_ready,
   output logic                  st_last
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  delivered;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      fifo_count;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [31:0]           mem [FIFO_DEPTH];
   logic                  done_q;

   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [CNT_W:0]        in_use;
   logic                  credit_ok;
   logic                  addr_lsb_unused;

   // Words in flight plus words buffered may never exceed the FIFO, so a
   // request is only issued when a slot is guaranteed for its data.
   assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign credit_ok = in_use < DEPTH_C;

   assign avm_read       = (state == S_ISSUE) && (remaining != '0) && credit_ok;
   assign avm_address    = addr_q;
   assign avm_byteenable = 4'hF;

   assign accept = avm_read & ~avm_waitrequest;
   assign push   = avm_readdatavalid & (outstanding != '0);
   assign pop    = st_valid & st_ready;

   assign st_valid = (fifo_count != '0);
   assign st_data  = st_valid ? mem[rd_ptr] : 32'h0;
   assign st_last  = st_valid & (delivered == (len_q - LEN_WIDTH'(1)));

   assign busy = (state != S_IDLE);
   assign done = done_q;

   assign addr_lsb_unused = ^base_addr[1:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         remaining   <= '0;
         delivered   <= '0;
         len_q       <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  if (length == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q    <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                     remaining <= length;
                     len_q     <= length;
                     delivered <= '0;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (accept && (remaining == LEN_WIDTH'(1))) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (pop && st_last) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (accept) begin
            addr_q    <= addr_q + ADDR_WIDTH'(4);
            remaining <= remaining - LEN_WIDTH'(1);
         end

         if (pop) begin
            delivered <= delivered + LEN_WIDTH'(1);
            rd_ptr    <= rd_ptr + PTR_W'(1);
         end

         if (push) wr_ptr <= wr_ptr + PTR_W'(1);

         // A return and an acceptance in the same cycle cancel out.
         case ({accept, push})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // NOTE: the data array has no reset; its contents are only visible while
   // fifo_count says a word is valid, and st_data is forced to 0 otherwise.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= avm_readdata;
   end

endmodule

// File: tb/tb_onchip_memory_read_master.sv
// Directed bench for onchip_memory_read_master with a pipelined Avalon slave
// model (configurable latency and waitrequest) and a stream monitor.
module tb_onchip_memory_read_master;

   localparam int AW = 14;
   localparam int LW = 13;
   localparam int FD = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] length;
   logic          busy;
   logic          done;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic [3:0]    avm_byteenable;
   logic          avm_waitrequest = 1'b0;
   logic [31:0]   avm_readdata = 32'h0;
   logic          avm_readdatavalid = 1'b0;
   logic [31:0]   st_data;
   logic          st_valid;
   logic          st_ready;
   logic          st_last;

   onchip_memory_read_master #(
      .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .avm_address(avm_address),
      .avm_read(avm_read), .avm_byteenable(avm_byteenable),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .st_data(st_data),
      .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } rsp_t;

   rsp_t          rsp_q[$];
   logic [AW-1:0] req_addr[$];
   int            req_cyc[$];
   logic [31:0]   rx_data[$];
   logic          rx_last[$];

   int   ncyc = 0;
   int   last_due = 0;
   int   lat_min = 1;
   int   lat_max = 1;
   int   wait_pct = 0;
   logic force_wait = 1'b0;
   int   n_acc = 0;
   int   n_ret = 0;
   int   n_pop = 0;
   int   max_occ = 0;

   int checks = 0;
   int failures = 0;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return {16'hD00D, 2'b00, a};
   endfunction

   // Slave model and stream monitor; DUT outputs are stable at the falling edge.
   always @(negedge clk) begin
      int lat;
      int due;
      ncyc++;
      if (n_ret - n_pop > max_occ) max_occ = n_ret - n_pop;
      if (reset_n && st_valid && st_ready) begin
         rx_data.push_back(st_data);
         rx_last.push_back(st_last);
         n_pop++;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == ncyc) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = mem_word(rsp_q[0].addr);
         void'(rsp_q.pop_front());
         n_ret++;
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'hDEAD_BEEF;
      end
      avm_waitrequest = force_wait || (wait_pct != 0 && $urandom_range(99) < wait_pct);
      if (reset_n && avm_read && !avm_waitrequest) begin
         lat = $urandom_range(lat_max, lat_min);
         due = ncyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         rsp_q.push_back('{addr: avm_address, due: due});
         req_addr.push_back(avm_address);
         req_cyc.push_back(ncyc);
         n_acc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      req_addr.delete();
      req_cyc.delete();
      rx_data.delete();
      rx_last.delete();
      n_acc = 0;
      n_ret = 0;
      n_pop = 0;
      max_occ = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_done"},     32'(done), 0);
      check({tag, "_avm_read"}, 32'(avm_read), 0);
      check({tag, "_avm_addr"}, 32'(avm_address), 0);
      check({tag, "_st_valid"}, 32'(st_valid), 0);
      check({tag, "_st_last"},  32'(st_last), 0);
      check({tag, "_st_data"},  st_data, 0);
      check({tag, "_byteen"},   32'(avm_byteenable), 32'hF);
   endtask

   // Called in cycle N+1 of a block; returns the offset of the done cycle from N.
   task automatic wait_done(input string tag, input int budget, output int k);
      k = 1;
      while (done !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      check({tag, "_done_seen"}, 32'(done), 1);
      check({tag, "_busy_at_done"}, 32'(busy), 0);
   endtask

   task automatic verify_block(input string tag, input logic [AW-1:0] base, input int len);
      int bad_data = 0;
      int bad_addr = 0;
      int last_cnt = 0;
      logic last_final;
      logic [AW-1:0] a;
      for (int i = 0; i < len; i++) begin
         a = AW'(int'(base) + 4 * i);
         if (i < rx_data.size() && rx_data[i] !== mem_word(a)) bad_data++;
         if (i < req_addr.size() && req_addr[i] !== a) bad_addr++;
      end
      foreach (rx_last[i]) if (rx_last[i]) last_cnt++;
      last_final = (rx_last.size() > 0) ? rx_last[rx_last.size() - 1] : 1'b0;
      check({tag, "_words"},     32'(rx_data.size()), 32'(len));
      check({tag, "_requests"},  32'(req_addr.size()), 32'(len));
      check({tag, "_bad_data"},  32'(bad_data), 0);
      check({tag, "_bad_addr"},  32'(bad_addr), 0);
      check({tag, "_last_cnt"},  32'(last_cnt), 1);
      check({tag, "_last_final"}, 32'(last_final), 1);
   endtask

   initial begin
      int k;
      int span;
      logic saw_valid;

      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      st_ready  = 1'b0;
      repeat (3) step();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      step();

      // Zero-wait 4-word block: done lands at N+7.
      clear_mon();
      st_ready = 1'b1;
      start = 1'b1; base_addr = 14'h0100; length = 13'd4;
      step();
      start = 1'b0;
      check("zw_busy_n1", 32'(busy), 1);
      check("zw_read_n1", 32'(avm_read), 1);
      check("zw_addr_n1", 32'(avm_address), 32'h100);
      wait_done("zw", 30, k);
      check("zw_done_cycle", 32'(k), 7);
      verify_block("zw", 14'h0100, 4);
      span = (req_cyc.size() >= 4) ? req_cyc[3] - req_cyc[0] : -1;
      check("zw_req_span", 32'(span), 3);
      step();
      check("zw_done_pulse", 32'(done), 0);

      // Backpressure: credit stops issue at FIFO_DEPTH words.
      clear_mon();
      st_ready = 1'b0;
      start = 1'b1; base_addr = 14'h0000; length = 13'd20;
      step();
      start = 1'b0;
      repeat (15) step();
      check("bp_req_count", 32'(n_acc), 8);
      check("bp_read_low", 32'(avm_read), 0);
      st_ready = 1'b1;
      step();
      st_ready = 1'b0;
      repeat (6) step();
      check("bp_req_after_pop", 32'(n_acc), 9);
      check("bp_read_low2", 32'(avm_read), 0);
      st_ready = 1'b1;
      wait_done("bp", 200, k);
      verify_block("bp", 14'h0000, 20);

      // Waitrequest stall on the second request.
      clear_mon();
      start = 1'b1; base_addr = 14'h0000; length = 13'd4;
      step();
      start = 1'b0;
      step();
      force_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("ws_hold_read", 32'(avm_read), 1);
         check("ws_hold_addr", 32'(avm_address), 32'h4);
         step();
      end
      force_wait = 1'b0;
      check("ws_hold_read4", 32'(avm_read), 1);
      check("ws_hold_addr4", 32'(avm_address), 32'h4);
      step();
      check("ws_next_addr", 32'(avm_address), 32'h8);
      wait_done("ws", 40, k);
      verify_block("ws", 14'h0000, 4);

      // Zero length: done next cycle, never busy, no reads.
      clear_mon();
      start = 1'b1; base_addr = 14'h0500; length = 13'd0;
      step();
      start = 1'b0;
      check("z0_done", 32'(done), 1);
      check("z0_busy", 32'(busy), 0);
      check("z0_read", 32'(avm_read), 0);
      step();
      check("z0_done_clr", 32'(done), 0);
      check("z0_busy2", 32'(busy), 0);
      check("z0_reqs", 32'(n_acc), 0);

      // Start while busy is ignored.
      clear_mon();
      start = 1'b1; base_addr = 14'h0040; length = 13'd5;
      step();
      start = 1'b0;
      step();
      start = 1'b1; base_addr = 14'h0800; length = 13'd2;
      step();
      start = 1'b0;
      check("sb_busy", 32'(busy), 1);
      wait_done("sb", 40, k);
      verify_block("sb", 14'h0040, 5);

      // Reset with three reads in flight; late returns must be dropped.
      clear_mon();
      lat_min = 4; lat_max = 4;
      st_ready = 1'b0;
      start = 1'b1; base_addr = 14'h0200; length = 13'd10;
      step();
      start = 1'b0;
      repeat (3) step();
      check("rst_inflight", 32'(n_acc - n_ret), 3);
      reset_n = 1'b0;
      step();
      check_reset_outputs("rst_mid");
      reset_n  = 1'b1;
      st_ready = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         saw_valid = saw_valid | st_valid;
      end
      check("rst_no_stale_valid", 32'(saw_valid), 0);
      check("rst_busy_after", 32'(busy), 0);
      lat_min = 1; lat_max = 1;

      // Full 4096-word block wrapping the address space.
      clear_mon();
      st_ready = 1'b1;
      start = 1'b1; base_addr = 14'h3FFC; length = 13'd4096;
      step();
      start = 1'b0;
      check("wrap_first_addr", 32'(avm_address), 32'h3FFC);
      wait_done("wrap", 5000, k);
      verify_block("wrap", 14'h3FFC, 4096);
      check("wrap_second_addr", (req_addr.size() > 1) ? 32'(req_addr[1]) : 32'hFFFF_FFFF, 32'h0);

      // Random latency, waitrequest and stream backpressure.
      clear_mon();
      lat_min = 1; lat_max = 5; wait_pct = 30;
      start = 1'b1; base_addr = 14'h1230; length = 13'd37;
      step();
      start = 1'b0;
      k = 0;
      while (done !== 1'b1 && k < 3000) begin
         st_ready = ($urandom_range(1) == 1);
         step();
         k++;
      end
      check("rnd_done_seen", 32'(done), 1);
      verify_block("rnd", 14'h1230, 37);
      check("rnd_max_occ_ok", 32'(max_occ <= FD), 1);
      wait_pct = 0;
      lat_max = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onchip_memory_read_master.md
# onchip_memory_read_master

Avalon-MM read master that streams a block of 32-bit words out of on-chip memory (or any pipelined Avalon-MM slave) onto a ready/valid stream. Software or a control FSM gives it a base address and a word count and pulses `start`. The block issues pipelined reads, buffers the returned data in an internal FIFO, and presents the words in order on the stream port. It is the initiator side of the on-chip memory slave interface, and it feeds the audio/sample datapath from RAM without Nios II involvement per word.

## Interface
- `ADDR_WIDTH`, 14: master byte-address width. 4096 words × 4 bytes.
- `LEN_WIDTH`, 13: word-count width. Legal range 0..4096.
- `FIFO_DEPTH`, 8: read-data buffer depth in words. Power of two, ≥2. It also bounds the number of reads in flight.

- `clk`  in  1  single clock domain
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches `base_addr`/`length` when idle
- `base_addr`  in  ADDR_WIDTH  first byte address; bits [1:0] ignored (treated as 0)
- `length`  in  LEN_WIDTH  number of 32-bit words to read
- `busy`  out  1  high from the cycle after an accepted `start` until the `done` cycle
- `done`  out  1  one-cycle pulse when the last word has been accepted on the stream
- `avm_address`  out  ADDR_WIDTH  byte address, word-aligned
- `avm_read`  out  1  read request
- `avm_byteenable`  out  4  constant 4'b1111
- `avm_waitrequest`  in  1  slave stall
- `avm_readdata`  in  32  read data
- `avm_readdatavalid`  in  1  read data qualifier
- `st_data`  out  32  stream word
- `st_valid`  out  1  stream word valid
- `st_ready`  in  1  sink accepts word
- `st_last`  out  1  qualifies the final word of the block (valid only with `st_valid`)

## Operation
- **State machine:** IDLE, ISSUE, DRAIN.
- **IDLE**
  - `start` with `length`≠0: latch address (with [1:0] forced to 0) and length into `remaining`, clear `delivered`, go to ISSUE.
  - `start` with `length`=0: pulse `done` on the next cycle and stay IDLE. `busy` stays 0.
- **ISSUE**
  - `avm_read` is asserted when `remaining`>0 and `outstanding + fifo_count < FIFO_DEPTH`.
  - A request is accepted in a cycle with `avm_read & !avm_waitrequest`. On acceptance: `avm_address` += 4 (wraps modulo 2^ADDR_WIDTH), `remaining`−1, `outstanding`+1.
  - Once asserted, `avm_read` and `avm_address` hold stable until accepted. The credit condition cannot fall while a request is pending, because returns move words from outstanding to FIFO and pops only add credit.
  - When the last request is accepted (`remaining` reaches 0), go to DRAIN.
- **Return path**
  - On `avm_readdatavalid`: push `avm_readdata` into the FIFO and decrement `outstanding`.
  - The FIFO never overflows, by the credit rule.
  - `avm_readdatavalid` while `outstanding`=0 is a slave protocol error. It is ignored (no push).
- **Stream**
  - FIFO head drives `st_data` / `st_valid`. A word pops on `st_valid & st_ready`, and `delivered` increments.
  - `st_last` = `st_valid` and (`delivered` = latched length − 1).
- **DRAIN**
  - Stay in DRAIN until the `st_last` word is accepted.
  - In that cycle, register a `done` pulse for the next cycle and return to IDLE. `busy` falls with `done`.
- **Simultaneous events**
  - A push and a pop in the same cycle leave `fifo_count` unchanged.
  - A return and a request acceptance in the same cycle leave `outstanding` unchanged.
- `start` while `busy` is ignored. Nothing is latched.
- **Reset mid-operation:** FSM goes to IDLE and all counters and the FIFO are cleared. Responses still in flight from the slave after reset are discarded, because `outstanding`=0.

## Timing
- **Reset values:** `busy`=0, `done`=0, `avm_read`=0, `avm_address`=0, `st_valid`=0, `st_last`=0, `st_data`=0. `avm_byteenable`=4'hF.
- **Start to first request:** `start` accepted in cycle N; `busy`=1 and `avm_read`=1 in N+1.
- **Request rate:** one request accepted per cycle when `avm_waitrequest`=0 and credit is available.
- **Read data to stream:** `avm_readdatavalid` in cycle M; `st_valid` for that word in M+1. The FIFO output is registered, with no combinational path from `avm_readdata` to `st_data`.
- **Stream backpressure:** `st_ready` has no combinational effect on `avm_read` in the same cycle. Credit is freed the cycle after a pop.
- **Completion:** the last word is accepted in cycle K; `done`=1 and `busy`=0 in K+1. A new `start` is accepted in K+1.
- **Zero-wait on-chip RAM** (read latency 1, `st_ready`=1): a 4-word block gives `done` at N+7.

## Test plan
- **Zero-wait block:** slave with waitrequest=0 and latency 1; base 0x0100, length 4, `st_ready`=1. Expect reads at 0x100, 0x104, 0x108, 0x10C on consecutive cycles; stream words in order with `st_last` on the 4th; `done` at N+7.
- **Backpressure credit:** length 20, FIFO_DEPTH 8, `st_ready`=0. Expect exactly 8 requests, then `avm_read`=0. Raise `st_ready` for 1 cycle: exactly 1 further request.
- **Waitrequest stall:** waitrequest high for 3 cycles on the 2nd request. Expect `avm_read` and `avm_address`=0x0004 held stable for all 4 cycles, with no duplicate or skipped address.
- **Length edge cases**
  - length 0: `done` at N+1, `busy` never 1, no `avm_read`.
  - length 4096 at base 0x3FFC: addresses wrap 0x3FFC → 0x0000; 4096 words delivered.
- **Start while busy / reset mid-block:** `start` during ISSUE is ignored (the original count completes). `reset_n`=0 with 3 reads outstanding: all outputs return to reset values the next cycle, and late `avm_readdatavalid` produces no `st_valid`.
- **Random latency:** slave latency 1–5 with random waitrequest and random `st_ready`, length 37. Expect the stream to equal the memory contents in order, `st_last` exactly once, and FIFO occupancy ≤ 8.
